my_nios_onchip_mem_reader: RTL and testbench



---
 rtl/my_nios_onchip_mem_reader_pkg.sv | 26 ++
 rtl/my_nios_onchip_mem_reader_if.sv | 43 ++++
 rtl/my_nios_onchip_mem_reader_fifo.sv | 72 +++++++
 rtl/my_nios_onchip_mem_reader.sv | 179 +++++++++++++++++
 tb/tb_my_nios_onchip_mem_reader.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/my_nios_onchip_mem_reader_pkg.sv
// Shared state encoding and memory geometry for the on-chip memory stream reader.
// MY_NIOS_MEM_READER_PACKET_EN widens the FIFO entry by SOP/EOP sideband bits.
package my_nios_mem_pkg;

  localparam int MEM_DEPTH  = 51200;
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

`ifdef MY_NIOS_MEM_READER_PACKET_EN
  localparam int SIDEBAND_W = 2;
`else
  localparam int SIDEBAND_W = 0;
`endif

  function automatic int fifo_width(input int data_w);
    return data_w + SIDEBAND_W;
  endfunction

endpackage

// File: rtl/my_nios_onchip_mem_reader_if.sv
// RAM s1 read port plus Avalon-ST source of the reader; master = reader side.
// Stream: a word transfers on each rising edge where st_valid && st_ready; st_valid
// never depends on st_ready. MY_NIOS_MEM_READER_PACKET_EN adds SOP/EOP.
interface my_nios_onchip_mem_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;
`ifdef MY_NIOS_MEM_READER_PACKET_EN
  logic              st_startofpacket;
  logic              st_endofpacket;
`endif

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input  mem_readdata,
    output st_data, st_valid,
    input  st_ready
`ifdef MY_NIOS_MEM_READER_PACKET_EN
    , output st_startofpacket, st_endofpacket
`endif
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output mem_readdata,
    input  st_data, st_valid,
    output st_ready
`ifdef MY_NIOS_MEM_READER_PACKET_EN
    , input st_startofpacket, st_endofpacket
`endif
  );

endinterface

// File: rtl/my_nios_onchip_mem_reader_fifo.sv
// Show-ahead synchronous FIFO; flush wins over push, and push is legal when
// full provided the same cycle pops. Head reads as zero while empty.
module my_nios_mem_reader_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/my_nios_onchip_mem_reader.sv
// Walks a word region of the on-chip RAM and streams it out with backpressure.
// MY_NIOS_MEM_READER_PACKET_EN adds SOP/EOP carried through the FIFO sideband.
module my_nios_onchip_mem_reader
  import my_nios_mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output state_t            dbg_state,
  my_nios_onchip_mem_reader_if.master bus
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FIFO_W = fifo_width(DATA_W);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic              error_q, error_d;
  logic              inflight_q;

  logic              issue;
  logic              flush;
  logic              push;
  logic              pop;
  logic              drain_ok;
  logic              range_bad;
  logic [ADDR_W:0]   cmd_end;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_wdata;
  logic [FIFO_W-1:0] fifo_rdata;

  assign cmd_end   = {1'b0, base} + {1'b0, length};
  assign range_bad = (cmd_end > DEPTH_L);

  // The issue gate counts the read still in flight, so a landing word always has a slot.
  assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
  assign pop       = !fifo_empty && bus.st_ready;
  assign push      = inflight_q && !flush;
  assign drain_ok  = !inflight_q &&
                     ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    error_d  = error_q;
    issue    = 1'b0;
    flush    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          if (length == '0) begin
            error_d = 1'b0;
            state_d = DONE;
          end else if (range_bad) begin
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            addr_d   = base;
            remain_d = length;
            error_d  = 1'b0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (occupancy < (CNT_W + 1)'(FIFO_DEPTH)) begin
          issue    = 1'b1;
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - ADDR_W'(1);
          if (remain_q == ADDR_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (drain_ok) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      error_q    <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      error_q    <= error_d;
      inflight_q <= issue;
    end
  end

`ifdef MY_NIOS_MEM_READER_PACKET_EN
  logic first_q, first_d;
  logic infl_sop_q;
  logic infl_eop_q;

  always_comb begin
    first_d = first_q;
    if ((state_q == IDLE || state_q == DONE) && start) first_d = 1'b1;
    else if (issue)                                     first_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_q    <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
    end else begin
      first_q    <= first_d;
      infl_sop_q <= issue && first_q;
      infl_eop_q <= issue && (remain_q == ADDR_W'(1));
    end
  end

  assign fifo_wdata           = {infl_sop_q, infl_eop_q, bus.mem_readdata};
  assign bus.st_startofpacket = fifo_rdata[DATA_W+1];
  assign bus.st_endofpacket   = fifo_rdata[DATA_W];
`else
  assign fifo_wdata = bus.mem_readdata;
`endif

  my_nios_mem_reader_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign bus.mem_address    = addr_q;
  assign bus.mem_chipselect = issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_clken      = 1'b1;
  assign bus.st_data        = fifo_rdata[DATA_W-1:0];
  assign bus.st_valid       = !fifo_empty;

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_my_nios_onchip_mem_reader.sv
// Scoreboard bench for my_nios_onchip_mem_reader: RAM model, command driver,
// stream monitor against an expected-word queue. Honors MY_NIOS_MEM_READER_PACKET_EN.
`timescale 1ns/1ps
module tb_my_nios_onchip_mem_reader;
  import my_nios_mem_pkg::*;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int DEPTH      = 51200;
  localparam int FIFO_DEPTH = 4;
`ifdef MY_NIOS_MEM_READER_PACKET_EN
  localparam int W = DATA_W + 2;
`else
  localparam int W = DATA_W;
`endif

  // ---------------- clock / reset ----------------
  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic              start   = 1'b0;
  logic              abort   = 1'b0;
  logic [ADDR_W-1:0] base    = '0;
  logic [ADDR_W-1:0] length  = '0;
  logic              busy;
  logic              done;
  logic              error;
  state_t            dbg_state;
  longint            cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  my_nios_onchip_mem_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  my_nios_onchip_mem_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base(base), .length(length),
    .abort(abort), .busy(busy), .done(done), .error(error), .dbg_state(dbg_state),
    .bus(bus)
  );

  // RAM with one-cycle read latency
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk)
    if (bus.mem_chipselect && bus.mem_clken)
      bus.mem_readdata <= (int'(bus.mem_address) < DEPTH) ? ram[bus.mem_address] : 32'hDEAD_BEEF;

  // sink ready: 0 = always high, 1 = toggle, 2 = random
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.st_ready = 1'b1;
      1:       bus.st_ready = ~bus.st_ready;
      default: bus.st_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_act;
  logic [W-1:0] mon_exp;
  int     outstanding = 0;
  int     reads = 0;
  int     done_cnt = 0;
  longint first_valid_cyc = -1;
  bit     busy_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      outstanding = 0;
    end else begin
      if (busy) busy_seen = 1;
      if (done) done_cnt++;
      if (bus.st_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.mem_chipselect) begin
        reads++;
        check("issue_gate", 64'(outstanding < FIFO_DEPTH), 64'd1);
        check("issue_addr_range", 64'(int'(bus.mem_address) < DEPTH), 64'd1);
      end
      if (bus.st_valid && bus.st_ready) begin
`ifdef MY_NIOS_MEM_READER_PACKET_EN
        mon_act = {bus.st_startofpacket, bus.st_endofpacket, bus.st_data};
`else
        mon_act = bus.st_data;
`endif
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL stream_extra: got 0x%0h expected no word", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          check("stream_word", 64'(mon_act), 64'(mon_exp));
        end
      end
      outstanding += int'(bus.mem_chipselect) - int'(bus.st_valid && bus.st_ready);
      if (abort && busy) begin
        exp_q.delete();
        outstanding = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input int b, input int l, output longint t0);
    @(posedge clk); #1;
    if (l != 0 && b + l <= DEPTH)
      for (int i = 0; i < l; i++) begin
`ifdef MY_NIOS_MEM_READER_PACKET_EN
        exp_q.push_back({i == 0, i == l - 1, ram[b + i]});
`else
        exp_q.push_back(ram[b + i]);
`endif
      end
    reads = 0;
    busy_seen = 0;
    first_valid_cyc = -1;
    t0 = cyc;
    start = 1'b1;
    base = ADDR_W'(b);
    length = ADDR_W'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_cmd(input string name, input longint t0, input bit exp_err,
                            input int exp_reads, input int exp_lat);
    longint lat = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done expected done within 3000 cycles", name);
    end else begin
      if (exp_lat >= 0) check({name, "_done_cycle"}, 64'(lat), 64'(exp_lat));
      check({name, "_error"}, 64'(error), 64'(exp_err));
      check({name, "_busy_at_done"}, 64'(busy), 64'd0);
      check({name, "_reads"}, 64'(reads), 64'(exp_reads));
      check({name, "_left_in_queue"}, 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check({name, "_done_width"}, 64'(done), 64'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    longint t0;
    int b, l, dc;
    bus.st_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;

    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_chipselect", 64'(bus.mem_chipselect), 64'd0);
    check("rst_address", 64'(bus.mem_address), 64'd0);
    check("rst_st_valid", 64'(bus.st_valid), 64'd0);
    check("rst_st_data", 64'(bus.st_data), 64'd0);
    check("rst_mem_write", 64'(bus.mem_write), 64'd0);
    check("rst_byteenable", 64'(bus.mem_byteenable), 64'hF);
    check("rst_clken", 64'(bus.mem_clken), 64'd1);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // basic streaming with sink always ready
    ready_mode = 0;
    send_cmd(16'h0010, 8, t0);
    finish_cmd("basic", t0, 1'b0, 8, 11);
    check("basic_first_valid", 64'(first_valid_cyc - t0), 64'd3);

    // toggling backpressure
    ready_mode = 1;
    send_cmd(int'($urandom_range(0, DEPTH - 20)), 20, t0);
    finish_cmd("toggle", t0, 1'b0, 20, -1);
    ready_mode = 0;

    // out-of-range command, then error held while idle
    send_cmd(51190, 11, t0);
    finish_cmd("range_err", t0, 1'b1, 0, 1);
    check("range_err_busy_seen", 64'(busy_seen), 64'd0);
    repeat (5) @(negedge clk);
    check("error_held", 64'(error), 64'd1);

    // exactly reaching the top of memory
    send_cmd(51190, 10, t0);
    finish_cmd("range_edge", t0, 1'b0, 10, 13);

    // abort mid-transfer
    send_cmd(int'($urandom_range(0, DEPTH - 100)), 100, t0);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    dc = done_cnt;
    @(negedge clk);
    check("abort_st_valid", 64'(bus.st_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_state", 64'(dbg_state), 64'(IDLE));
    repeat (10) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(dc));
    send_cmd(0, 2, t0);
    finish_cmd("after_abort", t0, 1'b0, 2, 5);

    // zero length
    send_cmd(int'($urandom_range(0, DEPTH - 1)), 0, t0);
    finish_cmd("zero_len", t0, 1'b0, 0, 1);
    check("zero_len_busy_seen", 64'(busy_seen), 64'd0);

    // start while busy is ignored
    send_cmd(int'($urandom_range(0, DEPTH - 12)), 12, t0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    base = ADDR_W'($urandom_range(0, 1000));
    length = 16'd5;
    @(posedge clk);
    #1 start = 1'b0;
    finish_cmd("start_busy", t0, 1'b0, 12, 15);

    // single word (SOP and EOP both set when packets are enabled)
    send_cmd(int'($urandom_range(0, DEPTH - 1)), 1, t0);
    finish_cmd("single", t0, 1'b0, 1, 4);

    // randomized commands with random backpressure
    ready_mode = 2;
    for (int n = 0; n < 8; n++) begin
      l = int'($urandom_range(1, 40));
      if ($urandom_range(0, 1) == 0) b = int'($urandom_range(0, DEPTH - l));
      else                           b = int'($urandom_range(DEPTH - 40, DEPTH - 1));
      send_cmd(b, l, t0);
      finish_cmd("random", t0, (b + l > DEPTH), (b + l > DEPTH) ? 0 : l, -1);
    end
    ready_mode = 0;

    // asynchronous reset mid-transfer
    send_cmd(int'($urandom_range(0, DEPTH - 50)), 50, t0);
    repeat (6) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    dc = done_cnt;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_st_valid", 64'(bus.st_valid), 64'd0);
    check("midrst_chipselect", 64'(bus.mem_chipselect), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt), 64'(dc));
    send_cmd(int'($urandom_range(0, DEPTH - 6)), 6, t0);
    finish_cmd("after_reset", t0, 1'b0, 6, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no completion expected finish within 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
